// File: rtl/cnn_sequencer_if.sv
// Signal bundle between the CNN frame sequencer and its surroundings.
// A word moves on a rising edge where valid and ready are both high; valid never waits on ready.
interface cnn_sequencer_if #(
    parameter int DATA_W = 16
);
    logic                 start;
    logic                 abort;
    logic                 in_valid;
    logic [DATA_W-1:0]    in_data;
    logic                 in_ready;
    logic [36*DATA_W-1:0] fm_buf;
    logic [9*DATA_W-1:0]  fm_res;
    logic                 out_valid;
    logic [DATA_W-1:0]    out_data;
    logic                 out_ready;
    logic                 busy;
    logic                 done;
    logic [1:0]           state;

    modport master (
        output start, abort, in_valid, in_data, fm_res, out_ready,
        input  in_ready, fm_buf, out_valid, out_data, busy, done, state
    );

    modport slave (
        input  start, abort, in_valid, in_data, fm_res, out_ready,
        output in_ready, fm_buf, out_valid, out_data, busy, done, state
    );
endinterface

// File: rtl/cnn_sequencer.sv
// Frame sequencer: loads a 6x6 map, waits for the external datapath to settle,
// captures its 3x3 result and streams it out row-major.
module cnn_sequencer #(
    parameter int DATA_W      = 16,
    parameter int COMPUTE_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    cnn_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [5:0] LAST_LOAD = 6'd35;
    localparam logic [3:0] LAST_OUT  = 4'd8;
    localparam logic [3:0] WAIT_LAST = 4'(COMPUTE_LAT - 1);

    state_t            state_q, state_d;
    logic [5:0]        load_idx;
    logic [3:0]        wait_cnt;
    logic [3:0]        out_idx;
    logic              done_q;
    logic [DATA_W-1:0] fm_mem  [36];
    logic [DATA_W-1:0] res_mem [9];

    logic load_we, wait_inc, res_latch, out_inc, frame_done, idx_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // abort overrides every other input, including start in IDLE
    always_comb begin
        state_d    = state_q;
        load_we    = 1'b0;
        wait_inc   = 1'b0;
        res_latch  = 1'b0;
        out_inc    = 1'b0;
        frame_done = 1'b0;
        idx_clear  = 1'b0;
        if (bus.abort) begin
            state_d   = IDLE;
            idx_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    idx_clear = 1'b1;
                    if (bus.start) state_d = LOAD;
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        load_we = 1'b1;
                        if (load_idx == LAST_LOAD) state_d = COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (wait_cnt == WAIT_LAST) begin
                        res_latch = 1'b1;
                        state_d   = DRAIN;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (out_idx == LAST_OUT) begin
                            frame_done = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            out_inc = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_idx <= '0;
            wait_cnt <= '0;
            out_idx  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= frame_done;
            if (idx_clear) begin
                load_idx <= '0;
                wait_cnt <= '0;
                out_idx  <= '0;
            end else begin
                if (load_we && load_idx != LAST_LOAD) load_idx <= load_idx + 6'd1;
                if (wait_inc) wait_cnt <= wait_cnt + 4'd1;
                if (out_inc)  out_idx  <= out_idx + 4'd1;
            end
        end
    end

    // fm_mem is only written in LOAD, so fm_buf holds through COMPUTE, DRAIN and IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 36; k++) fm_mem[k] <= '0;
            for (int j = 0; j < 9; j++)  res_mem[j] <= '0;
        end else begin
            if (load_we) fm_mem[load_idx] <= bus.in_data;
            if (res_latch) begin
                for (int j = 0; j < 9; j++) res_mem[j] <= bus.fm_res[j*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar k = 0; k < 36; k++) begin : g_fm_buf
        assign bus.fm_buf[k*DATA_W +: DATA_W] = fm_mem[k];
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_data  = res_mem[out_idx];
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_cnn_sequencer.sv
// Directed bench for cnn_sequencer: a relu/maxpool stand-in drives fm_res from fm_buf,
// with expected results hand-derived for ramp inputs.
module tb_cnn_sequencer;
    localparam int DW = 16;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cnn_sequencer_if #(.DATA_W(DW)) bus ();
    cnn_sequencer_if #(.DATA_W(DW)) bus_l1 ();
    cnn_sequencer_if #(.DATA_W(DW)) bus_l15 ();

    // the latency-variant builds follow the main stimulus
    assign bus_l1.start      = bus.start;
    assign bus_l1.abort      = bus.abort;
    assign bus_l1.in_valid   = bus.in_valid;
    assign bus_l1.in_data    = bus.in_data;
    assign bus_l1.out_ready  = bus.out_ready;
    assign bus_l15.start     = bus.start;
    assign bus_l15.abort     = bus.abort;
    assign bus_l15.in_valid  = bus.in_valid;
    assign bus_l15.in_data   = bus.in_data;
    assign bus_l15.out_ready = bus.out_ready;

    // 2x2 max pool over a relu'd 6x6 map
    function automatic logic [9*DW-1:0] pool_model(input logic [36*DW-1:0] fm);
        logic [9*DW-1:0] r;
        logic [DW-1:0]   w, m;
        r = '0;
        for (int j = 0; j < 9; j++) begin
            m = '0;
            for (int dr = 0; dr < 2; dr++) begin
                for (int dc = 0; dc < 2; dc++) begin
                    w = fm[((2*(j/3) + dr)*6 + 2*(j%3) + dc)*DW +: DW];
                    if (w[DW-1]) w = '0;
                    if (w > m) m = w;
                end
            end
            r[j*DW +: DW] = m;
        end
        return r;
    endfunction

    assign bus.fm_res     = pool_model(bus.fm_buf);
    assign bus_l1.fm_res  = pool_model(bus_l1.fm_buf);
    assign bus_l15.fm_res = pool_model(bus_l15.fm_buf);

    cnn_sequencer #(.DATA_W(DW), .COMPUTE_LAT(2))  dut     (.clk(clk), .rst_n(rst_n), .bus(bus));
    cnn_sequencer #(.DATA_W(DW), .COMPUTE_LAT(1))  dut_l1  (.clk(clk), .rst_n(rst_n), .bus(bus_l1));
    cnn_sequencer #(.DATA_W(DW), .COMPUTE_LAT(15)) dut_l15 (.clk(clk), .rst_n(rst_n), .bus(bus_l15));

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int first_m = -1;
    int first_1 = -1;
    int first_15 = -1;
    logic [DW-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.busy) busy_cnt++;
        if (bus.done) done_cnt++;
        if (bus.out_valid && first_m < 0) first_m = cyc;
        if (bus_l1.out_valid && first_1 < 0) first_1 = cyc;
        if (bus_l15.out_valid && first_15 < 0) first_15 = cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // input ramp base+k makes every pooled value the bottom-right word of its 2x2 block
    task automatic push_frame(input int base);
        for (int j = 0; j < 9; j++)
            exp_q.push_back(DW'(base + 6*(2*(j/3) + 1) + 2*(j%3) + 1));
    endtask

    function automatic int buf_errors(input int base);
        int bad = 0;
        for (int k = 0; k < 36; k++)
            if (bus.fm_buf[k*DW +: DW] !== DW'(base + k)) bad++;
        return bad;
    endfunction

    task automatic load_frame(input int base, input bit gap, input int stop_at, input int restart_at);
        int k = 0;
        int budget = 0;
        bit phase = 1'b1;
        bit pulsed = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (k < stop_at && budget < 200) begin
            budget++;
            bus.start = 1'b0;
            if (k == restart_at && !pulsed) begin
                bus.start = 1'b1;
                pulsed = 1'b1;
            end
            bus.in_valid = !gap || phase;
            bus.in_data  = bus.in_valid ? DW'(base + k) : 16'hdead;
            if (bus.in_ready && bus.in_valid) begin
                if (k == 35) begin
                    acc_cyc = cyc;
                    check("load_last_state", bus.state, ST_LOAD);
                end
                k++;
            end
            if (gap) phase = ~phase;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        if (budget >= 200) check("load_timeout", k, stop_at);
    endtask

    task automatic drain(input int bp_at, input int rst_at);
        int idx = 0;
        int budget = 0;
        bit bp_done = 1'b0;
        bit rst_hit = 1'b0;
        while (exp_q.size() > 0 && !rst_hit && budget < 200) begin
            @(negedge clk);
            budget++;
            if (bus.out_valid) begin
                if (idx == rst_at) begin
                    check("rst_pre_state", bus.state, ST_DRAIN);
                    #2 rst_n = 1'b0;
                    #1;
                    check("rst_state", bus.state, ST_IDLE);
                    check("rst_busy", bus.busy, 0);
                    check("rst_out_valid", bus.out_valid, 0);
                    check("rst_in_ready", bus.in_ready, 0);
                    check("rst_done", bus.done, 0);
                    check("rst_out_data", bus.out_data, 0);
                    check("rst_fm_buf_zero", bus.fm_buf == '0, 1);
                    exp_q.delete();
                    rst_hit = 1'b1;
                end else begin
                    if (idx == bp_at && !bp_done) begin
                        bus.out_ready = 1'b0;
                        repeat (3) begin
                            @(negedge clk);
                            check("bp_hold_data", bus.out_data, exp_q[0]);
                            check("bp_hold_valid", bus.out_valid, 1);
                        end
                        bus.out_ready = 1'b1;
                        bp_done = 1'b1;
                    end
                    check("out_data", bus.out_data, exp_q.pop_front());
                    idx++;
                end
            end
        end
        if (!rst_hit) begin
            check("drain_left", exp_q.size(), 0);
            @(negedge clk);
            check("done_pulse", bus.done, 1);
            check("idle_after_frame", bus.busy, 0);
            @(negedge clk);
            check("done_single", bus.done, 0);
        end
    endtask

    int done_before;

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", bus.state, ST_IDLE);
        check("reset_busy", bus.busy, 0);
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_done", bus.done, 0);
        check("reset_out_data", bus.out_data, 0);
        check("reset_fm_buf", bus.fm_buf == '0, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // single frame, continuous input
        busy_cnt = 0;
        done_cnt = 0;
        push_frame(1);
        load_frame(1, 1'b0, 36, -1);
        check("t1_compute", bus.state, ST_COMPUTE);
        drain(-1, -1);
        check("t1_busy_cycles", busy_cnt, 36 + 2 + 9);
        check("t1_done_count", done_cnt, 1);
        check("lat2_first_valid", first_m - acc_cyc, 3);
        repeat (30) @(negedge clk);
        check("lat1_first_valid", first_1 - acc_cyc, 2);
        check("lat15_first_valid", first_15 - acc_cyc, 16);

        // input gaps
        push_frame(7);
        load_frame(7, 1'b1, 36, -1);
        check("gap_compute", bus.state, ST_COMPUTE);
        check("gap_buf_words", buf_errors(7), 0);
        drain(-1, -1);
        check("gap_buf_hold", buf_errors(7), 0);

        // output backpressure on word 4
        done_before = done_cnt;
        push_frame(50);
        load_frame(50, 1'b0, 36, -1);
        drain(4, -1);
        repeat (2) @(negedge clk);
        check("bp_done_count", done_cnt - done_before, 1);

        // abort at load index 20
        done_before = done_cnt;
        load_frame(90, 1'b0, 20, -1);
        check("abort_pre_state", bus.state, ST_LOAD);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_state", bus.state, ST_IDLE);
        check("abort_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - done_before, 0);
        push_frame(100);
        load_frame(100, 1'b0, 36, -1);
        check("abort_next_compute", bus.state, ST_COMPUTE);
        drain(-1, -1);

        // start and abort together in IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_idle", bus.state, ST_IDLE);

        // reset during DRAIN at output index 5
        push_frame(200);
        load_frame(200, 1'b0, 36, -1);
        drain(-1, 5);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd5;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_in_ready", bus.in_ready, 0);
            check("post_rst_state", bus.state, ST_IDLE);
        end
        bus.in_valid = 1'b0;

        // full frame with a stray start pulse mid-LOAD
        done_before = done_cnt;
        push_frame(300);
        load_frame(300, 1'b0, 36, 10);
        check("restart_compute", bus.state, ST_COMPUTE);
        check("restart_buf_words", buf_errors(300), 0);
        drain(-1, -1);
        repeat (2) @(negedge clk);
        check("restart_done_count", done_cnt - done_before, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, miscompares so far %0d", n_miss);
        $fatal(1, "watchdog expired");
    end
endmodule
